// File: rtl/addsub_seq.sv
// Sequential adder/subtractor: CHUNK bits of the carry chain per clock.
// Captured operands keep the result independent of later input changes.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             rm;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] sumn;
  logic             cmsb;
  logic             last;
  int               base;

  // One chunk of the carry chain plus the merged next sum image
  always_comb begin
    base = int'(idx) * CHUNK;
    csum = {1'b0, ra[base +: CHUNK]}
         + {1'b0, rb[base +: CHUNK]}
         + {{CHUNK{1'b0}}, carry};
    sumn = sum;
    sumn[base +: CHUNK] = csum[CHUNK-1:0];
    // Carry into the MSB recovered from the MSB sum bit
    cmsb = ra[WIDTH-1] ^ rb[WIDTH-1] ^ sumn[WIDTH-1];
    last = (idx == IW'(NCHUNK - 1));
  end

  // Control FSM, operand capture, chunked sum and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      rm        <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra       <= a;
            rb       <= b ^ {WIDTH{m}};
            rm       <= m;
            carry    <= m;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          sum   <= sumn;
          carry <= csum[CHUNK];
          idx   <= idx + 1'b1;
          if (last) begin
            carryout  <= csum[CHUNK] ^ rm;
            overflow  <= cmsb ^ csum[CHUNK];
            zero      <= (sumn == '0);
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
